aes_round_sequencer: RTL and testbench

- Synchronous, parametrised control block for AES. Replaces event-driven round sequencing with a clocked FSM.
- One start/done handshake covers both encryption and decryption for 128/192/256-bit keys.
- Drives an external single-round datapath and round-key store: issues key index, initial/final flags and per-round data; collects each round result.
- Adds a response watchdog, abort and optional CBC chaining.

---
 rtl/aes_round_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_aes_round_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// Clocked round sequencer for an external single-round AES datapath (enc/dec, 128/192/256-bit keys).
// Optional CBC chaining is enabled by defining AES_SEQ_CBC_EN.
module aes_round_sequencer #(
    parameter int unsigned TIMEOUT   = 64,
    parameter int unsigned TMO_W     = 7,
    parameter int unsigned KEY_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 encOrDec,
    input  logic [2:0]           keySize,
    input  logic [0:127]         messageIn,
`ifdef AES_SEQ_CBC_EN
    input  logic                 iv_load,
    input  logic [0:127]         iv,
`endif
    output logic                 ready,
    output logic                 done,
    output logic                 err,
    output logic [0:127]         messageOut,
    output logic                 rnd_valid,
    output logic                 rnd_initial,
    output logic                 rnd_final,
    output logic                 rnd_encOrDec,
    output logic [KEY_IDX_W-1:0] rnd_keyIdx,
    output logic [0:127]         rnd_dataIn,
    input  logic [0:127]         rnd_dataOut,
    input  logic                 rnd_done
);

    localparam int unsigned BLK_W = 128;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FIN, ERR} state_t;

    state_t               state, stateNext;
    logic [KEY_IDX_W-1:0] cnt, cntNext;
    logic [KEY_IDX_W-1:0] nr, nrNext;
    logic [TMO_W-1:0]     wdog, wdogNext, wdogInc;
    logic                 modeNext;
    logic [0:BLK_W-1]     dataNext, msgNext;
    logic                 errNext, doneNext, readyNext, validNext;
    logic                 initialNext, finalNext;
    logic [KEY_IDX_W-1:0] keyIdxNext;
`ifdef AES_SEQ_CBC_EN
    logic [0:BLK_W-1]     chain, chainNext, chainUse;
    logic [0:BLK_W-1]     ctReg, ctNext;
`endif

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            nr           <= '0;
            wdog         <= '0;
            rnd_encOrDec <= 1'b0;
            rnd_dataIn   <= '0;
            messageOut   <= '0;
            err          <= 1'b0;
            done         <= 1'b0;
            ready        <= 1'b1;
            rnd_valid    <= 1'b0;
            rnd_initial  <= 1'b0;
            rnd_final    <= 1'b0;
            rnd_keyIdx   <= '0;
`ifdef AES_SEQ_CBC_EN
            chain        <= '0;
            ctReg        <= '0;
`endif
        end else begin
            state        <= stateNext;
            cnt          <= cntNext;
            nr           <= nrNext;
            wdog         <= wdogNext;
            rnd_encOrDec <= modeNext;
            rnd_dataIn   <= dataNext;
            messageOut   <= msgNext;
            err          <= errNext;
            done         <= doneNext;
            ready        <= readyNext;
            rnd_valid    <= validNext;
            rnd_initial  <= initialNext;
            rnd_final    <= finalNext;
            rnd_keyIdx   <= keyIdxNext;
`ifdef AES_SEQ_CBC_EN
            chain        <= chainNext;
            ctReg        <= ctNext;
`endif
        end
    end

    // Next-state, datapath capture and next output values
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        nrNext    = nr;
        wdogNext  = wdog;
        wdogInc   = wdog + TMO_W'(1);
        modeNext  = rnd_encOrDec;
        dataNext  = rnd_dataIn;
        msgNext   = messageOut;
        errNext   = err;
        doneNext  = 1'b0;
`ifdef AES_SEQ_CBC_EN
        chainNext = chain;
        ctNext    = ctReg;
        chainUse  = iv_load ? iv : chain;
`endif

        unique case (state)
            IDLE: begin
`ifdef AES_SEQ_CBC_EN
                chainNext = chainUse;
`endif
                if (start && ready && !abort) begin
                    stateNext = ISSUE;
                    cntNext   = '0;
                    modeNext  = encOrDec;
                    errNext   = 1'b0;
                    if (keySize == 3'b100)      nrNext = KEY_IDX_W'(14);
                    else if (keySize == 3'b010) nrNext = KEY_IDX_W'(12);
                    else                        nrNext = KEY_IDX_W'(10);
`ifdef AES_SEQ_CBC_EN
                    dataNext = encOrDec ? (messageIn ^ chainUse) : messageIn;
                    ctNext   = messageIn;
`else
                    dataNext = messageIn;
`endif
                end
            end
            ISSUE: begin
                if (abort) begin
                    stateNext = IDLE;
                end else begin
                    wdogNext  = '0;
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                // A result arriving on the expiry cycle still counts
                if (abort) begin
                    stateNext = IDLE;
                end else if (rnd_done) begin
                    dataNext = rnd_dataOut;
                    if (cnt == nr) begin
                        stateNext = FIN;
                    end else begin
                        cntNext   = cnt + KEY_IDX_W'(1);
                        stateNext = ISSUE;
                    end
                end else if (wdogInc == TMO_W'(TIMEOUT)) begin
                    stateNext = ERR;
                    errNext   = 1'b1;
                end else begin
                    wdogNext = wdogInc;
                end
            end
            FIN: begin
                if (abort) begin
                    stateNext = IDLE;
                end else begin
                    stateNext = IDLE;
                    doneNext  = 1'b1;
`ifdef AES_SEQ_CBC_EN
                    if (rnd_encOrDec) begin
                        msgNext   = rnd_dataIn;
                        chainNext = rnd_dataIn;
                    end else begin
                        msgNext   = rnd_dataIn ^ chain;
                        chainNext = ctReg;
                    end
`else
                    msgNext = rnd_dataIn;
`endif
                end
            end
            ERR: begin
                errNext = 1'b1;
                if (abort) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase

        readyNext   = (stateNext == IDLE);
        validNext   = (stateNext == ISSUE);
        initialNext = (stateNext != IDLE) && (cntNext == '0);
        finalNext   = (stateNext != IDLE) && (cntNext == nrNext);
        if (stateNext == IDLE)  keyIdxNext = '0;
        else if (modeNext)      keyIdxNext = cntNext;
        else                    keyIdxNext = nrNext - cntNext;
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Randomized self-checking bench for aes_round_sequencer with a behavioural round-core model.
// Exercises the CBC path as well when AES_SEQ_CBC_EN is defined.
module tb_aes_round_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, abort, encOrDec;
    logic [2:0]   keySize;
    logic [0:127] messageIn;
    logic         ready, done, err;
    logic [0:127] messageOut;
    logic         rnd_valid, rnd_initial, rnd_final, rnd_encOrDec;
    logic [3:0]   rnd_keyIdx;
    logic [0:127] rnd_dataIn;
    logic [0:127] rnd_dataOut = '0;
    logic         rnd_done = 1'b0;
`ifdef AES_SEQ_CBC_EN
    logic         iv_load;
    logic [0:127] iv;
`endif

    int           checks = 0;
    int           errors = 0;
    int           coreLat = 1;
    bit           coreAlive = 1'b1;
    logic [127:0] modelChain = '0;

    always #5 clk = ~clk;

    aes_round_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .encOrDec(encOrDec), .keySize(keySize), .messageIn(messageIn),
`ifdef AES_SEQ_CBC_EN
        .iv_load(iv_load), .iv(iv),
`endif
        .ready(ready), .done(done), .err(err), .messageOut(messageOut),
        .rnd_valid(rnd_valid), .rnd_initial(rnd_initial), .rnd_final(rnd_final),
        .rnd_encOrDec(rnd_encOrDec), .rnd_keyIdx(rnd_keyIdx),
        .rnd_dataIn(rnd_dataIn), .rnd_dataOut(rnd_dataOut), .rnd_done(rnd_done)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pat(input int idx);
        logic [7:0] b;
        b = {4'h0, idx[3:0]};
        return {16{b}};
    endfunction

    function automatic int nrOf(input logic [2:0] ks);
        if (ks == 3'b100) return 14;
        if (ks == 3'b010) return 12;
        return 10;
    endfunction

    // Whole-block result: every round key pattern XORed in, in key-schedule order
    function automatic logic [127:0] aesModel(input logic [127:0] x, input int nr, input bit enc);
        logic [127:0] y;
        y = x;
        for (int r = 0; r <= nr; r++) y = y ^ pat(enc ? r : nr - r);
        return y;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Round core: answers L cycles after rnd_valid with dataIn ^ key pattern
    int           rem = 0;
    bit           busy = 1'b0;
    logic [127:0] capData = '0;
    logic [3:0]   capIdx = '0;
    always @(negedge clk) begin
        rnd_done = 1'b0;
        if (!rst) begin
            busy = 1'b0;
        end else begin
            if (busy) begin
                rem--;
                if (rem == 0) begin
                    rnd_done    = 1'b1;
                    rnd_dataOut = capData ^ pat(int'(capIdx));
                    busy        = 1'b0;
                end
            end
            if (rnd_valid && coreAlive) begin
                busy    = 1'b1;
                rem     = coreLat;
                capData = rnd_dataIn;
                capIdx  = rnd_keyIdx;
            end
        end
    end

    // Called at a falling edge; returns at the falling edge of the done cycle
    task automatic runBlock(input bit enc, input logic [2:0] ks, input logic [127:0] msg, input int lat);
        int nr, pulses, doneCyc;
        bit seen, readyBad;
        logic [127:0] exp, res, newChain;
        nr = nrOf(ks);
        coreLat = lat;
        start = 1'b1; encOrDec = enc; keySize = ks; messageIn = msg;
        if (enc) begin
            res = aesModel(msg ^ modelChain, nr, 1'b1);
            exp = res; newChain = res;
        end else begin
            res = aesModel(msg, nr, 1'b0);
            exp = res ^ modelChain; newChain = msg;
        end
`ifdef AES_SEQ_CBC_EN
        modelChain = newChain;
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
`ifdef AES_SEQ_CBC_EN
        iv_load = 1'b0;
`endif
        messageIn = rand128(); keySize = 3'($urandom); encOrDec = 1'($urandom);
        pulses = 0; seen = 1'b0; readyBad = 1'b0; doneCyc = -1;
        for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                check("accept", rnd_valid, 1);
                check("err_clear", err, 0);
            end
            if (rnd_valid) begin
                check("keyIdx", rnd_keyIdx, enc ? pulses : nr - pulses);
                check("initial", rnd_initial, pulses == 0);
                check("final", rnd_final, pulses == nr);
                pulses++;
            end
            if (done) begin
                seen = 1'b1;
                doneCyc = cyc;
            end else if (ready) begin
                readyBad = 1'b1;
            end
        end
        check("done_seen", seen, 1);
        check("done_cycle", doneCyc, (nr + 1) * (lat + 1) + 1);
        check("pulses", pulses, nr + 1);
        check("messageOut", messageOut, exp);
        check("ready_busy", readyBad, 0);
    endtask

    task automatic waitPulses(input int n);
        int seenP;
        seenP = 0;
        for (int cyc = 0; cyc < 300 && seenP < n; cyc++) begin
            @(negedge clk);
            if (rnd_valid) seenP++;
        end
        check("pulse_wait", seenP, n);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        logic [127:0] prevOut;
        bit doneBad;
        rst = 1'b0; start = 1'b0; abort = 1'b0; encOrDec = 1'b0; keySize = '0; messageIn = '0;
`ifdef AES_SEQ_CBC_EN
        iv_load = 1'b0; iv = '0;
`endif
        repeat (2) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_msgOut", messageOut, 0);
        check("rst_valid", rnd_valid, 0);
        check("rst_initial", rnd_initial, 0);
        check("rst_final", rnd_final, 0);
        check("rst_keyIdx", rnd_keyIdx, 0);
        rst = 1'b1;
        @(negedge clk);

        runBlock(1'b1, 3'b000, rand128(), 1);
        @(negedge clk);
        check("idle_ready", ready, 1);
        check("done_width", done, 0);

        runBlock(1'b0, 3'b100, rand128(), 3);
        @(negedge clk);
        check("idle_ready2", ready, 1);

        runBlock(1'b1, 3'b010, rand128(), 1);
        runBlock(1'b0, 3'b111, rand128(), 1);
        @(negedge clk);

        repeat (6) runBlock(1'($urandom), 3'($urandom), rand128(), int'($urandom_range(1, 4)));
        @(negedge clk);

        // Abort on the same cycle as start: nothing accepted
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_start_valid", rnd_valid, 0);
        check("abort_start_ready", ready, 1);

        // Watchdog
        prevOut = messageOut;
        coreAlive = 1'b0;
        start = 1'b1; encOrDec = 1'b1; keySize = 3'b000; messageIn = rand128();
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 0; cyc <= 65; cyc++) begin
            @(negedge clk);
            if (cyc == 64) check("err_early", err, 0);
            if (cyc == 65) check("err_set", err, 1);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_start_ready", ready, 0);
        check("err_start_valid", rnd_valid, 0);
        check("err_hold", err, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("err_abort_ready", ready, 1);
        check("err_after_abort", err, 1);
        check("err_msgOut", messageOut, prevOut);
        coreAlive = 1'b1;
        runBlock(1'b0, 3'b000, rand128(), 2);
        @(negedge clk);

        // Abort during round 5
        prevOut = messageOut;
        coreLat = 2;
        start = 1'b1; encOrDec = 1'b1; keySize = 3'b100; messageIn = rand128();
        @(posedge clk);
        #1 start = 1'b0;
        waitPulses(6);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        doneBad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) doneBad = 1'b1;
        end
        check("abort_no_done", doneBad, 0);
        check("abort_msgOut", messageOut, prevOut);
        check("abort_ready", ready, 1);

        // Reset during round 7
        start = 1'b1; encOrDec = 1'b0; keySize = 3'b010; messageIn = rand128();
        @(posedge clk);
        #1 start = 1'b0;
        waitPulses(8);
        rst = 1'b0;
        modelChain = '0;
        @(negedge clk);
        check("mid_rst_msgOut", messageOut, 0);
        check("mid_rst_ready", ready, 1);
        check("mid_rst_valid", rnd_valid, 0);
        check("mid_rst_done", done, 0);
        rst = 1'b1;
        @(negedge clk);
        runBlock(1'b1, 3'b010, rand128(), 1);
        @(negedge clk);

`ifdef AES_SEQ_CBC_EN
        begin
            logic [127:0] p1, p2, c1, c2, ivv;
            ivv = 128'h000102030405060708090a0b0c0d0e0f;
            p1 = rand128(); p2 = rand128();
            iv_load = 1'b1; iv = ivv; modelChain = ivv;
            @(negedge clk);
            iv_load = 1'b0;
            runBlock(1'b1, 3'b000, p1, 1);
            c1 = messageOut;
            runBlock(1'b1, 3'b000, p2, 1);
            c2 = messageOut;
            @(negedge clk);
            iv_load = 1'b1; iv = ivv; modelChain = ivv;
            runBlock(1'b0, 3'b000, c1, 2);
            check("cbc_p1", messageOut, p1);
            runBlock(1'b0, 3'b000, c2, 2);
            check("cbc_p2", messageOut, p2);
            @(negedge clk);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
